// File: rtl/grf_pkg.sv
// Shared defaults for the writeback register file.
// Read data is combinational; there is no backpressure.
package grf_pkg;
  localparam int DEF_DW   = 32;
  localparam int DEF_AW   = 5;
  localparam int DEF_CW   = 16;
  localparam int NREG     = 2 ** DEF_AW;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/wb_grf_if.sv
// Register-file bus: writeback port, two decode read ports, write statistics.
// Reads are combinational; the bus has no handshake or backpressure.
interface wb_grf_if
  import grf_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int CW = DEF_CW
);
  logic          RegWriteW;
  logic [AW-1:0] WriteRegW;
  logic [DW-1:0] WriteDataW;
  logic [AW-1:0] ReadReg1;
  logic [AW-1:0] ReadReg2;
  logic [DW-1:0] ReadData1;
  logic [DW-1:0] ReadData2;
  logic [CW-1:0] WriteCount;
  logic [AW-1:0] LastWriteReg;
  logic [DW-1:0] LastWriteData;

  modport master (
    output RegWriteW, WriteRegW, WriteDataW, ReadReg1, ReadReg2,
    input  ReadData1, ReadData2, WriteCount, LastWriteReg, LastWriteData
  );

  modport slave (
    input  RegWriteW, WriteRegW, WriteDataW, ReadReg1, ReadReg2,
    output ReadData1, ReadData2, WriteCount, LastWriteReg, LastWriteData
  );
endinterface

// File: rtl/grf_read_port.sv
// One combinational read port: index mux, register-0 and reset forcing to 0.
// Zero latency, no backpressure; GRF_BYPASS_EN forwards same-cycle write data.
module grf_read_port
  import grf_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic                       i_rst_n,
  input  logic [AW-1:0]              i_idx,
  input  logic [(2**AW)-1:0][DW-1:0] i_regs,
  input  logic                       i_wr_en,
  input  logic [AW-1:0]              i_wr_idx,
  input  logic [DW-1:0]              i_wr_dat,
  output logic [DW-1:0]              o_dat
);
`ifndef GRF_BYPASS_EN
  logic w_unused_wr;
  assign w_unused_wr = &{1'b0, i_wr_en, i_wr_idx, i_wr_dat};
`endif

  always_comb begin
    o_dat = i_regs[i_idx];
`ifdef GRF_BYPASS_EN
    // i_wr_en already excludes index 0 and reset, so forwarding is always a real write
    if (i_wr_en && (i_wr_idx == i_idx)) o_dat = i_wr_dat;
`endif
    if (!i_rst_n || (i_idx == AW'(ZERO_REG))) o_dat = '0;
  end
endmodule

// File: rtl/wb_grf.sv
// Writeback general register file with write counter and last-write record; optional GRF_BYPASS_EN.
// Writes land on the rising Clk edge, reads are combinational; no backpressure.
module wb_grf
  import grf_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int CW = DEF_CW
) (
  input  logic     Clk,
  input  logic     Rst_n,
  wb_grf_if.slave  bus
);
  localparam int NR = 2 ** AW;

  logic [NR-1:0][DW-1:0] r_regs;
  logic [CW-1:0]         r_wcnt;
  logic [AW-1:0]         r_last_reg;
  logic [DW-1:0]         r_last_dat;
  logic                  w_wr_en;

  assign w_wr_en = bus.RegWriteW && (bus.WriteRegW != AW'(ZERO_REG)) && Rst_n;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_regs     <= '0;
      r_wcnt     <= '0;
      r_last_reg <= '0;
      r_last_dat <= '0;
    end else if (w_wr_en) begin
      r_regs[bus.WriteRegW] <= bus.WriteDataW;
      r_wcnt                <= r_wcnt + CW'(1);
      r_last_reg            <= bus.WriteRegW;
      r_last_dat            <= bus.WriteDataW;
    end
  end

  assign bus.WriteCount    = r_wcnt;
  assign bus.LastWriteReg  = r_last_reg;
  assign bus.LastWriteData = r_last_dat;

  grf_read_port #(.DW(DW), .AW(AW)) u_rd1 (
    .i_rst_n  (Rst_n),
    .i_idx    (bus.ReadReg1),
    .i_regs   (r_regs),
    .i_wr_en  (w_wr_en),
    .i_wr_idx (bus.WriteRegW),
    .i_wr_dat (bus.WriteDataW),
    .o_dat    (bus.ReadData1)
  );

  grf_read_port #(.DW(DW), .AW(AW)) u_rd2 (
    .i_rst_n  (Rst_n),
    .i_idx    (bus.ReadReg2),
    .i_regs   (r_regs),
    .i_wr_en  (w_wr_en),
    .i_wr_idx (bus.WriteRegW),
    .i_wr_dat (bus.WriteDataW),
    .o_dat    (bus.ReadData2)
  );
endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf (CW narrowed to 8 so the counter wrap is short).
// The same-cycle read expectation follows GRF_BYPASS_EN.
module tb_wb_grf;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 Clk = ~Clk;

  wb_grf_if #(.DW(32), .AW(5), .CW(8)) bus ();

  wb_grf #(.DW(32), .AW(5), .CW(8)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  task automatic wr(input logic [4:0] idx, input logic [31:0] dat);
    bus.RegWriteW  = 1'b1;
    bus.WriteRegW  = idx;
    bus.WriteDataW = dat;
    @(posedge Clk);
    #1;
    bus.RegWriteW  = 1'b0;
  endtask

  task automatic test_reset();
    bus.RegWriteW = 1'b1; bus.WriteRegW = 5'd5; bus.WriteDataW = 32'h55;
    bus.ReadReg1 = 5'd5; bus.ReadReg2 = 5'd31;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (bus.ReadData1 !== 32'h0) begin errors++; $display("FAIL rst_hold_rd1: got %h want 0", bus.ReadData1); end
    bus.RegWriteW = 1'b0;
    Rst_n = 1'b1;
    #1;
    checks++;
    if (bus.ReadData1 !== 32'h0) begin errors++; $display("FAIL rst_rd1: got %h want 0", bus.ReadData1); end
    checks++;
    if (bus.ReadData2 !== 32'h0) begin errors++; $display("FAIL rst_rd2: got %h want 0", bus.ReadData2); end
    checks++;
    if (bus.WriteCount !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", bus.WriteCount); end
    checks++;
    if (bus.LastWriteReg !== 5'd0 || bus.LastWriteData !== 32'h0) begin
      errors++; $display("FAIL rst_last: got %0d/%h want 0/0", bus.LastWriteReg, bus.LastWriteData);
    end
  endtask

  task automatic test_write();
    wr(5'd8, 32'hDEADBEEF);
    bus.ReadReg1 = 5'd8; bus.ReadReg2 = 5'd8;
    #1;
    checks++;
    if (bus.ReadData1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd1: got %h want deadbeef", bus.ReadData1); end
    checks++;
    if (bus.ReadData2 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_same_idx_rd2: got %h want deadbeef", bus.ReadData2); end
    checks++;
    if (bus.WriteCount !== 8'd1) begin errors++; $display("FAIL wr_cnt: got %0d want 1", bus.WriteCount); end
    checks++;
    if (bus.LastWriteReg !== 5'd8 || bus.LastWriteData !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_last: got %0d/%h want 8/deadbeef", bus.LastWriteReg, bus.LastWriteData);
    end
  endtask

  task automatic test_zero_reg();
    wr(5'd0, 32'h12345678);
    bus.ReadReg1 = 5'd0;
    #1;
    checks++;
    if (bus.ReadData1 !== 32'h0) begin errors++; $display("FAIL zero_rd: got %h want 0", bus.ReadData1); end
    checks++;
    if (bus.WriteCount !== 8'd1) begin errors++; $display("FAIL zero_cnt: got %0d want 1", bus.WriteCount); end
    checks++;
    if (bus.LastWriteReg !== 5'd8 || bus.LastWriteData !== 32'hDEADBEEF) begin
      errors++; $display("FAIL zero_last: got %0d/%h want 8/deadbeef", bus.LastWriteReg, bus.LastWriteData);
    end
    bus.WriteRegW = 5'd9; bus.WriteDataW = 32'h99999999;
    @(posedge Clk);
    #1;
    bus.ReadReg1 = 5'd9;
    #1;
    checks++;
    if (bus.ReadData1 !== 32'h0 || bus.WriteCount !== 8'd1) begin
      errors++; $display("FAIL wen_low: got %h/%0d want 0/1", bus.ReadData1, bus.WriteCount);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
`ifdef GRF_BYPASS_EN
    exp_same = 32'hA5A5A5A5;
`else
    exp_same = 32'h00000001;
`endif
    wr(5'd3, 32'h1);
    bus.RegWriteW = 1'b1; bus.WriteRegW = 5'd3; bus.WriteDataW = 32'hA5A5A5A5;
    bus.ReadReg1 = 5'd8; bus.ReadReg2 = 5'd3;
    #1;
    checks++;
    if (bus.ReadData2 !== exp_same) begin errors++; $display("FAIL same_cycle_rd2: got %h want %h", bus.ReadData2, exp_same); end
    checks++;
    if (bus.ReadData1 !== 32'hDEADBEEF) begin errors++; $display("FAIL indep_rd1: got %h want deadbeef", bus.ReadData1); end
    @(posedge Clk);
    #1;
    bus.RegWriteW = 1'b0;
    #1;
    checks++;
    if (bus.ReadData2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL next_cycle_rd2: got %h want a5a5a5a5", bus.ReadData2); end
    checks++;
    if (bus.WriteCount !== 8'd3) begin errors++; $display("FAIL byp_cnt: got %0d want 3", bus.WriteCount); end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 4; i++) wr(5'(i), 32'(i * 32'h11));
    bus.ReadReg1 = 5'd1; bus.ReadReg2 = 5'd4;
    #1;
    checks++;
    if (bus.ReadData1 !== 32'h11 || bus.ReadData2 !== 32'h44) begin
      errors++; $display("FAIL pre_rst: got %h/%h want 11/44", bus.ReadData1, bus.ReadData2);
    end
    #1;
    Rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ReadData1 !== 32'h0 || bus.ReadData2 !== 32'h0) begin
      errors++; $display("FAIL mid_rst_rd: got %h/%h want 0/0", bus.ReadData1, bus.ReadData2);
    end
    checks++;
    if (bus.WriteCount !== 8'd0 || bus.LastWriteReg !== 5'd0 || bus.LastWriteData !== 32'h0) begin
      errors++; $display("FAIL mid_rst_cnt: got %0d/%0d/%h want 0/0/0", bus.WriteCount, bus.LastWriteReg, bus.LastWriteData);
    end
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    bus.ReadReg2 = 5'd3;
    #1;
    checks++;
    if (bus.ReadData1 !== 32'h0 || bus.ReadData2 !== 32'h0) begin
      errors++; $display("FAIL post_rst_rd: got %h/%h want 0/0", bus.ReadData1, bus.ReadData2);
    end
  endtask

  task automatic test_back_to_back();
    bus.RegWriteW = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.WriteRegW  = 5'((i % 31) + 1);
      bus.WriteDataW = 32'(i);
      @(posedge Clk);
      #1;
      if (i == 254) begin
        checks++;
        if (bus.WriteCount !== 8'd255) begin errors++; $display("FAIL cnt_max: got %0d want 255", bus.WriteCount); end
      end
    end
    bus.RegWriteW = 1'b0;
    bus.ReadReg1 = 5'd8;
    #1;
    checks++;
    if (bus.WriteCount !== 8'd0) begin errors++; $display("FAIL cnt_wrap: got %0d want 0", bus.WriteCount); end
    checks++;
    if (bus.LastWriteReg !== 5'd8 || bus.LastWriteData !== 32'd255) begin
      errors++; $display("FAIL wrap_last: got %0d/%0d want 8/255", bus.LastWriteReg, bus.LastWriteData);
    end
    checks++;
    if (bus.ReadData1 !== 32'd255) begin errors++; $display("FAIL wrap_rd: got %0d want 255", bus.ReadData1); end
  endtask

  initial begin
    bus.RegWriteW = 1'b0; bus.WriteRegW = '0; bus.WriteDataW = '0;
    bus.ReadReg1 = '0; bus.ReadReg2 = '0;
    test_reset();
    test_write();
    test_zero_reg();
    test_bypass();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
